// File: rtl/fetch_arbiter.sv
// fetch_arbiter: shares one program-memory read channel among several fetchers.
// Requests are granted round-robin; fetchers asking for the same address in the
// grant cycle share a single memory transaction and all receive the returned word.
module fetch_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   parameter int NUM_CONSUMERS = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
   input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
   output logic [DATA_BITS-1:0]     consumer_read_data    [NUM_CONSUMERS],
   output logic                     mem_read_valid,
   output logic [ADDR_BITS-1:0]     mem_read_address,
   input  logic                     mem_read_ready,
   input  logic [DATA_BITS-1:0]     mem_read_data
);

   localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   // Registered state and outputs
   state_t                   r_state;
   logic [PTR_W-1:0]         r_rr_ptr;
   logic [NUM_CONSUMERS-1:0] r_grant_mask;
   logic                     r_mem_valid;
   logic [ADDR_BITS-1:0]     r_mem_addr;
   logic [NUM_CONSUMERS-1:0] r_ready;
   logic [DATA_BITS-1:0]     r_data [NUM_CONSUMERS];

   // Next-state values
   state_t                   w_state_nxt;
   logic [PTR_W-1:0]         w_rr_nxt;
   logic [NUM_CONSUMERS-1:0] w_mask_nxt;
   logic                     w_mem_valid_nxt;
   logic [ADDR_BITS-1:0]     w_mem_addr_nxt;
   logic [NUM_CONSUMERS-1:0] w_ready_nxt;
   logic [DATA_BITS-1:0]     w_data_nxt [NUM_CONSUMERS];

   // Arbitration results
   logic                     w_found_hi;
   logic                     w_found_lo;
   logic [PTR_W-1:0]         w_win_hi;
   logic [PTR_W-1:0]         w_win_lo;
   logic                     w_found;
   logic [PTR_W-1:0]         w_winner;
   logic [PTR_W-1:0]         w_rr_inc;
   logic [ADDR_BITS-1:0]     w_win_addr;
   logic [NUM_CONSUMERS-1:0] w_match;

   // Round-robin search: first requester at or above rr_ptr, else first requester overall (wrap)
   always_comb begin
      w_found_hi = 1'b0;
      w_win_hi   = '0;
      w_found_lo = 1'b0;
      w_win_lo   = '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
         if (consumer_read_valid[i] && !w_found_hi && (i >= int'(r_rr_ptr))) begin
            w_found_hi = 1'b1;
            w_win_hi   = PTR_W'(i);
         end
         if (consumer_read_valid[i] && !w_found_lo) begin
            w_found_lo = 1'b1;
            w_win_lo   = PTR_W'(i);
         end
      end
   end

   assign w_found  = w_found_hi | w_found_lo;
   assign w_winner = w_found_hi ? w_win_hi : w_win_lo;
   assign w_rr_inc = (w_winner == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : (w_winner + PTR_W'(1));

   // Winner's address and the set of requesters that can share its transaction (full-width compare)
   always_comb begin
      w_win_addr = '0;
      w_match    = '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
         if (PTR_W'(i) == w_winner) begin
            w_win_addr = consumer_read_address[i];
         end
      end
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
         w_match[i] = consumer_read_valid[i] && (consumer_read_address[i] == w_win_addr);
      end
   end

   // Next-state and next-output logic; everything holds unless a transition says otherwise
   always_comb begin
      w_state_nxt     = r_state;
      w_rr_nxt        = r_rr_ptr;
      w_mask_nxt      = r_grant_mask;
      w_mem_valid_nxt = r_mem_valid;
      w_mem_addr_nxt  = r_mem_addr;
      w_ready_nxt     = r_ready;
      w_data_nxt      = r_data;
      unique case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_mem_addr_nxt  = w_win_addr;
               w_mem_valid_nxt = 1'b1;
               w_mask_nxt      = w_match;
               w_rr_nxt        = w_rr_inc;
               w_state_nxt     = S_WAIT;
            end
         end
         S_WAIT: begin
            // Requests arriving now are left for a later grant; the mask is frozen
            if (mem_read_ready) begin
               w_mem_valid_nxt = 1'b0;
               w_ready_nxt     = r_grant_mask;
               for (int i = 0; i < NUM_CONSUMERS; i++) begin
                  if (r_grant_mask[i]) begin
                     w_data_nxt[i] = mem_read_data;
                  end
               end
               w_state_nxt = S_RESPOND;
            end
         end
         S_RESPOND: begin
            w_ready_nxt = '0;
            w_mask_nxt  = '0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_grant_mask <= '0;
         r_mem_valid  <= 1'b0;
         r_mem_addr   <= '0;
         r_ready      <= '0;
         for (int i = 0; i < NUM_CONSUMERS; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_state      <= w_state_nxt;
         r_rr_ptr     <= w_rr_nxt;
         r_grant_mask <= w_mask_nxt;
         r_mem_valid  <= w_mem_valid_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_ready      <= w_ready_nxt;
         r_data       <= w_data_nxt;
      end
   end

   assign consumer_read_ready = r_ready;
   assign consumer_read_data  = r_data;
   assign mem_read_valid      = r_mem_valid;
   assign mem_read_address    = r_mem_addr;

endmodule
